// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Multi-digit native BCD up/down counter with prescaler, parallel
//            load, wrap detection and per-digit change flags. All outputs
//            are registered.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
  parameter int DIGITS          = 3,
  parameter int CLOCKS_PER_STEP = 1,
  parameter int MIN_VALUE       = 0,
  parameter int MAX_VALUE       = 999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  updated,
  output logic [DIGITS-1:0]     digit_changed,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int BCD_WIDTH = 4 * DIGITS;

  function automatic logic [BCD_WIDTH-1:0] to_bcd(input int value);
    logic [BCD_WIDTH-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Digit 9 rolls to 0 and carries into the next digit.
  function automatic logic [BCD_WIDTH-1:0] bcd_inc(input logic [BCD_WIDTH-1:0] v);
    logic [BCD_WIDTH-1:0] r;
    logic                 carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit 0 rolls to 9 and borrows from the next digit.
  function automatic logic [BCD_WIDTH-1:0] bcd_dec(input logic [BCD_WIDTH-1:0] v);
    logic [BCD_WIDTH-1:0] r;
    logic                 borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [BCD_WIDTH-1:0] MIN_BCD   = to_bcd(MIN_VALUE);
  localparam logic [BCD_WIDTH-1:0] MAX_BCD   = to_bcd(MAX_VALUE);
  localparam logic [31:0]          STEP_LAST = 32'(CLOCKS_PER_STEP - 1);

  generate
    if (DIGITS < 1 || DIGITS > 8 || CLOCKS_PER_STEP < 1 || MIN_VALUE < 0 ||
        MIN_VALUE > MAX_VALUE || longint'(MAX_VALUE) >= pow10(DIGITS)) begin : g_bad_params
      $error("bcd_updown_counter: invalid DIGITS/CLOCKS_PER_STEP/MIN_VALUE/MAX_VALUE");
    end
  endgenerate

  logic [31:0]          pre;
  logic [31:0]          next_pre;
  logic [BCD_WIDTH-1:0] next_bcd;
  logic [DIGITS-1:0]    next_dc;
  logic                 next_wrap;
  logic                 next_lerr;
  logic                 step;
  logic                 digits_ok;
  logic                 lo_ok;
  logic                 hi_ok;

  // A lower bound of zero is always met; skip the compare to avoid a
  // constant-true unsigned comparison.
  generate
    if (MIN_VALUE == 0) begin : g_lo_zero
      assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign lo_ok = (load_bcd >= MIN_BCD);
    end
  endgenerate

  // With every digit in 0..9, packed BCD compares like the decimal number.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_bcd[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    hi_ok = (load_bcd <= MAX_BCD);
  end

  // Next count, prescaler and pulse flags; load has priority over a step.
  always_comb begin
    step      = en && (pre == STEP_LAST);
    next_bcd  = bcd;
    next_pre  = pre;
    next_wrap = 1'b0;
    next_lerr = 1'b0;
    if (load) begin
      next_pre = '0;
      if (digits_ok && lo_ok && hi_ok) begin
        next_bcd = load_bcd;
      end else begin
        next_bcd  = MIN_BCD;
        next_lerr = 1'b1;
      end
    end else if (en) begin
      if (step) begin
        next_pre = '0;
        if (up) begin
          if (bcd == MAX_BCD) begin
            next_bcd  = MIN_BCD;
            next_wrap = 1'b1;
          end else begin
            next_bcd = bcd_inc(bcd);
          end
        end else begin
          if (bcd == MIN_BCD) begin
            next_bcd  = MAX_BCD;
            next_wrap = 1'b1;
          end else begin
            next_bcd = bcd_dec(bcd);
          end
        end
      end else begin
        next_pre = pre + 32'd1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      next_dc[i] = (next_bcd[4*i +: 4] != bcd[4*i +: 4]);
    end
  end

  // Register count, prescaler and all one-cycle pulses together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd           <= MIN_BCD;
      pre           <= '0;
      updated       <= 1'b0;
      digit_changed <= '0;
      wrap          <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      bcd           <= next_bcd;
      pre           <= next_pre;
      updated       <= (next_bcd != bcd);
      digit_changed <= next_dc;
      wrap          <= next_wrap;
      load_err      <= next_lerr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter
// Brief    : Three counter configurations driven by shared randomized
//            stimulus and compared every cycle against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [31:0] ld = '0;
  logic        cmp_on = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  logic [11:0] bcd_a;  logic upd_a; logic [2:0] dc_a; logic wrap_a; logic lerr_a;
  logic [7:0]  bcd_b;  logic upd_b; logic [1:0] dc_b; logic wrap_b; logic lerr_b;
  logic [3:0]  bcd_c;  logic upd_c; logic [0:0] dc_c; logic wrap_c; logic lerr_c;

  bcd_updown_counter #(.DIGITS(3), .CLOCKS_PER_STEP(1), .MIN_VALUE(0), .MAX_VALUE(999)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bcd(ld[11:0]),
    .bcd(bcd_a), .updated(upd_a), .digit_changed(dc_a), .wrap(wrap_a), .load_err(lerr_a));

  bcd_updown_counter #(.DIGITS(2), .CLOCKS_PER_STEP(4), .MIN_VALUE(5), .MAX_VALUE(42)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bcd(ld[7:0]),
    .bcd(bcd_b), .updated(upd_b), .digit_changed(dc_b), .wrap(wrap_b), .load_err(lerr_b));

  bcd_updown_counter #(.DIGITS(1), .CLOCKS_PER_STEP(1), .MIN_VALUE(7), .MAX_VALUE(7)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bcd(ld[3:0]),
    .bcd(bcd_c), .updated(upd_c), .digit_changed(dc_c), .wrap(wrap_c), .load_err(lerr_c));

  // ---------------------------------------------------------------- model
  typedef struct {
    int         val;
    int         pre;
    logic       upd;
    logic [7:0] dc;
    logic       wrap;
    logic       lerr;
  } model_t;

  model_t ma, mb, mc;

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic model_t mreset(input int mn);
    model_t m;
    m.val = mn; m.pre = 0; m.upd = 0; m.dc = '0; m.wrap = 0; m.lerr = 0;
    return m;
  endfunction

  function automatic model_t mstep(input model_t s, input int nd, input int mn,
                                   input int mx, input int cps, input logic e,
                                   input logic u, input logic l, input logic [31:0] lb);
    model_t n;
    int     old;
    int     p;
    n      = s;
    old    = s.val;
    n.wrap = 0;
    n.lerr = 0;
    if (l) begin
      bit ok;
      int v;
      ok = 1;
      v  = 0;
      for (int i = nd - 1; i >= 0; i--) begin
        int d;
        d = int'(lb[4*i +: 4]);
        if (d > 9) ok = 0;
        v = v * 10 + d;
      end
      if (ok && v >= mn && v <= mx) n.val = v;
      else begin n.val = mn; n.lerr = 1; end
      n.pre = 0;
    end else if (e) begin
      if (s.pre == cps - 1) begin
        n.pre = 0;
        if (u) begin
          if (old == mx) begin n.val = mn; n.wrap = 1; end
          else n.val = old + 1;
        end else begin
          if (old == mn) begin n.val = mx; n.wrap = 1; end
          else n.val = old - 1;
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    n.dc = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      n.dc[i] = ((old / p) % 10) != ((n.val / p) % 10);
      p = p * 10;
    end
    n.upd = (n.val != old);
    return n;
  endfunction

  // Model advances on the same edges as the counters.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mreset(0);
      mb <= mreset(5);
      mc <= mreset(7);
    end else begin
      ma <= mstep(ma, 3, 0, 999, 1, en, up, load, ld);
      mb <= mstep(mb, 2, 5, 42, 4, en, up, load, ld);
      mc <= mstep(mc, 1, 7, 7, 1, en, up, load, ld);
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input int nd, input model_t m,
                         input logic [31:0] b, input logic u, input logic [7:0] dc,
                         input logic w, input logic le);
    chk({tag, ".bcd"}, b, to_bcd(m.val, nd));
    chk({tag, ".updated"}, 32'(u), 32'(m.upd));
    chk({tag, ".digit_changed"}, 32'(dc), 32'(m.dc));
    chk({tag, ".wrap"}, 32'(w), 32'(m.wrap));
    chk({tag, ".load_err"}, 32'(le), 32'(m.lerr));
  endtask

  // Every cycle, all three counters against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk_dut("a", 3, ma, 32'(bcd_a), upd_a, 8'(dc_a), wrap_a, lerr_a);
      chk_dut("b", 2, mb, 32'(bcd_b), upd_b, 8'(dc_b), wrap_b, lerr_b);
      chk_dut("c", 1, mc, 32'(bcd_c), upd_c, 8'(dc_c), wrap_c, lerr_c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    ld   = v;
    cyc(1);
    load = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int picks[9];
    picks = '{0, 4, 5, 6, 41, 42, 43, 998, 999};

    cyc(2);
    chk("reset.bcd_a", 32'(bcd_a), 32'h000);
    chk("reset.bcd_b", 32'(bcd_b), 32'h05);
    chk("reset.bcd_c", 32'(bcd_c), 32'h7);
    chk("reset.pulses_a", {28'd0, upd_a, dc_a != 3'b000, wrap_a, lerr_a}, 32'h0);
    rst = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    cyc(10);
    chk("up10.bcd_a", 32'(bcd_a), 32'h010);
    chk("up10.dc_a", 32'(dc_a), 32'b011);
    chk("up10.bcd_b", 32'(bcd_b), 32'h07);
    chk("up10.c_wrap_noupd", {30'd0, wrap_c, upd_c}, 32'b10);

    do_load(32'h099);
    chk("load099.bcd_a", 32'(bcd_a), 32'h099);
    chk("load99.b_err", {23'd0, lerr_b, bcd_b}, 32'h105);
    cyc(1);
    chk("step100.a", {19'd0, dc_a, bcd_a}, {19'd0, 3'b111, 12'h100});

    do_load(32'h999);
    cyc(1);
    chk("wrap_up.a", {18'd0, wrap_a, dc_a, bcd_a}, {18'd0, 1'b1, 3'b111, 12'h000});
    up = 1'b0;
    cyc(1);
    chk("wrap_dn.a", {18'd0, wrap_a, dc_a, bcd_a}, {18'd0, 1'b1, 3'b111, 12'h999});

    do_load(32'h037);
    chk("load37.b", {23'd0, lerr_b, bcd_b}, 32'h037);
    do_load(32'h037);
    chk("reload37.b_upd", 32'(upd_b), 32'd0);
    do_load(32'h03A);
    chk("load3A.b", {23'd0, lerr_b, bcd_b}, 32'h105);

    // Asynchronous reset while counting at 523.
    up = 1'b1;
    do_load(32'h522);
    cyc(1);
    chk("at523.a", 32'(bcd_a), 32'h523);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.a", {16'd0, upd_a, wrap_a, lerr_a, dc_a != 3'b000, bcd_a}, 32'h000);
    chk("async_rst.b", 32'(bcd_b), 32'h05);
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    chk("cps_hold.b", 32'(bcd_b), 32'h05);
    cyc(1);
    chk("cps_step.b", 32'(bcd_b), 32'h06);
    cyc(2);
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(1);
    chk("en_gap_hold.b", 32'(bcd_b), 32'h06);
    cyc(1);
    chk("en_gap_step.b", 32'(bcd_b), 32'h07);

    // Randomized phase; direction is sticky so bounds get reached.
    for (int k = 0; k < 4000; k++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) up = ~up;
      load = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       ld = $urandom;
        1:       ld = to_bcd(int'($urandom_range(0, 999)), 3);
        default: ld = to_bcd(picks[$urandom_range(0, 8)], 3);
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rnd_rst.bcd_a", 32'(bcd_a), 32'h000);
        @(negedge clk);
        rst = 1'b1;
      end else begin
        cyc(1);
      end
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Native multi-digit BCD up/down counter with prescaler, parallel load, wrap detection and per-digit change flags. Counts directly in BCD, so no binary-to-BCD converter is needed and the digit count is not limited by conversion depth. Sits between the clock-enable logic and the display drivers (seven-segment multiplexer, digit scanners), replacing the binary-counter-plus-converter-plus-pulse chain.

## Interface
- `DIGITS`, 3, number of BCD digits (1..8); `BCD_WIDTH = 4*DIGITS`
- `CLOCKS_PER_STEP`, 1, enabled clocks per count step (1..2**31-1)
- `MIN_VALUE`, 0, lower bound, decimal integer, 0 <= MIN_VALUE <= MAX_VALUE
- `MAX_VALUE`, 999, upper bound, decimal integer, < 10**DIGITS
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `en`  in  1  count enable; gates the prescaler
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `load`  in  1  synchronous parallel load request
- `load_bcd`  in  BCD_WIDTH  value to load, digit 0 in bits [3:0]
- `bcd`  out  BCD_WIDTH  current count, digit 0 in bits [3:0]
- `updated`  out  1  one-cycle pulse: `bcd` changed this cycle
- `digit_changed`  out  DIGITS  one-cycle mask: bit i set when digit i changed
- `wrap`  out  1  one-cycle pulse: count wrapped MAX->MIN or MIN->MAX
- `load_err`  out  1  one-cycle pulse: rejected load value

## Operation
- MIN_VALUE/MAX_VALUE converted to BCD constants at elaboration; elaboration error if bounds invalid.
- Ordering: with all digits valid (0..9), packed BCD unsigned compare equals numeric compare; used for range checks.
- Prescaler `pre` (32 bit): while `en`=1, counts 0..CLOCKS_PER_STEP-1 and wraps; `step` = `en` && `pre`==CLOCKS_PER_STEP-1. `en`=0 holds `pre`.
- Step up: if `bcd`==MAX -> MIN, `wrap`=1; else BCD increment, digit 9 -> 0 with carry into next digit.
- Step down: if `bcd`==MIN -> MAX, `wrap`=1; else BCD decrement, digit 0 -> 9 with borrow.
- Load (priority over step): if every digit <= 9 and MIN <= `load_bcd` <= MAX, `bcd` <= `load_bcd`; else `bcd` <= MIN and `load_err`=1. Load clears `pre` to 0; no step that cycle, no `wrap`.
- `updated` = (new `bcd` != old `bcd`); `digit_changed[i]` = digit i differs. A load of the current value gives `updated`=0.
- MIN_VALUE==MAX_VALUE: every step wraps to the same value: `wrap`=1, `updated`=0.
- `up` sampled only on the step cycle; changing it never disturbs `pre`.

## Timing
- Reset (async assert, sync-safe deassert at design level): `bcd`=MIN, `pre`=0, `updated`=0, `digit_changed`=0, `wrap`=0, `load_err`=0.
- All outputs registered. `bcd` and its `updated`/`digit_changed`/`wrap`/`load_err` pulses become visible on the same edge and last exactly one cycle.
- Latency: `load` sampled at edge N -> new `bcd` visible after edge N. Step at edge N when `pre`==CLOCKS_PER_STEP-1 and `en`=1.
- First step after reset or load: CLOCKS_PER_STEP enabled cycles later.
- CLOCKS_PER_STEP=1: steps every cycle `en`=1; back-to-back pulses allowed.
- Reset asserted mid-count: all state returns to reset values immediately, independent of `clk`.
- No combinational path from inputs to outputs.

## Test plan
- DIGITS=3, MIN=0, MAX=999, CPS=1, `up`=1, `en`=1 from reset: `bcd` 000->001 ... 009->010 (`digit_changed`=3'b011), 099->100 (3'b111), 999->000 with `wrap`=1, `updated`=1 every cycle.
- Same config, `up`=0 from 000: next `bcd`=999, `wrap`=1, `digit_changed`=3'b111; 100->099, `wrap`=0.
- DIGITS=2, MIN=5, MAX=42, CPS=4: steps on every 4th enabled cycle; `en` low 3 cycles mid-period delays step by exactly 3; up-count 42->05 with `wrap`=1; down 05->42 with `wrap`=1.
- Load with MIN=5, MAX=42: `load_bcd`=8'h37 -> `bcd`=37, `load_err`=0, `pre`=0; 8'h3A (invalid digit) -> `bcd`=05, `load_err`=1; 8'h43 -> 05, `load_err`=1; load 8'h37 while at 37 -> `updated`=0; `load` with `step` same cycle -> load wins, no `wrap`.
- MIN=MAX=7, DIGITS=1: every step `wrap`=1, `updated`=0, `bcd` stays 4'h7.
- Assert `rst` low between edges while counting at 523: `bcd`=MIN and all pulses 0 before next edge; after release, first step after CPS enabled cycles.
